// File: rtl/cal_sample.sv
// rtl/cal_sample.sv - per-channel offset/gain calibration of a sample frame
// One frame per sample_clk edge; channels share one multiplier in a 2-stage pipeline.
module cal_sample #(
   parameter int W              = 16,
   parameter int N_CH           = 4,
   parameter int GF             = 14,
   parameter int OFFSET_DEFAULT = 3500,
   localparam int AW            = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                sample_clk,
   input  logic [N_CH*W-1:0]   sample_in,
   input  logic                bypass,
   input  logic                cal_we,
   input  logic                cal_sel,
   input  logic [AW-1:0]       cal_addr,
   input  logic [W-1:0]        cal_data,
   output logic [N_CH*W-1:0]   sample_out,
   output logic                out_valid,
   output logic                busy,
   output logic [7:0]          overrun_cnt
);

   localparam int CW = $clog2(N_CH + 1);
   localparam logic signed [2*W:0] MAXV = {{(W+2){1'b0}}, {(W-1){1'b1}}};
   localparam logic signed [2*W:0] MINV = {{(W+2){1'b1}}, {(W-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, CALC, COMMIT} state_t;
   state_t state, state_nxt;

   logic s1, s2, s3;
   logic evt, accept, issue, last;
   logic signed [W-1:0] snap     [N_CH];
   logic signed [W-1:0] off_sh   [N_CH];
   logic signed [W-1:0] gain_sh  [N_CH];
   logic signed [W-1:0] off_act  [N_CH];
   logic signed [W-1:0] gain_act [N_CH];
   logic signed [W-1:0] res      [N_CH];
   logic                byp_q;
   logic [CW-1:0]       idx;
   logic [AW-1:0]       issue_ch;
   logic                v1;
   logic [AW-1:0]       ch1;
   logic signed [W:0]   diff;
   logic signed [2*W:0] prod, shifted;
   logic signed [W-1:0] result_c;

   assign evt       = s2 & ~s3;
   assign busy      = (state != IDLE);
   assign out_valid = (state == COMMIT);
   assign accept    = evt && (state == IDLE);
   assign issue     = (state == CALC) && (32'(idx) < N_CH);
   assign issue_ch  = idx[AW-1:0];
   assign last      = v1 && (32'(ch1) == N_CH - 1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (evt) state_nxt = CALC;
         CALC:    if (last) state_nxt = COMMIT;
         COMMIT:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Stage 2: floor shift (arithmetic) then clamp to the W-bit range
   always_comb begin
      prod     = diff * gain_act[ch1];
      shifted  = prod >>> GF;
      result_c = shifted[W-1:0];
      if (shifted > MAXV)
         result_c = MAXV[W-1:0];
      else if (shifted < MINV)
         result_c = MINV[W-1:0];
      if (byp_q)
         result_c = snap[ch1];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1          <= 1'b0;
         s2          <= 1'b0;
         s3          <= 1'b0;
         overrun_cnt <= 8'd0;
         sample_out  <= '0;
         byp_q       <= 1'b0;
         idx         <= '0;
         v1          <= 1'b0;
         ch1         <= '0;
         diff        <= '0;
         for (int c = 0; c < N_CH; c++) begin
            snap[c]     <= '0;
            res[c]      <= '0;
            off_sh[c]   <= W'(OFFSET_DEFAULT);
            off_act[c]  <= W'(OFFSET_DEFAULT);
            gain_sh[c]  <= W'(1 << GF);
            gain_act[c] <= W'(1 << GF);
         end
      end else begin
         s1 <= sample_clk;
         s2 <= s1;
         s3 <= s2;

         if (cal_we && (32'(cal_addr) < N_CH)) begin
            if (cal_sel)
               gain_sh[cal_addr] <= cal_data;
            else
               off_sh[cal_addr] <= cal_data;
         end

         if (evt && busy && (overrun_cnt != 8'hFF))
            overrun_cnt <= overrun_cnt + 8'd1;

         // Active set takes the shadow value seen before any write in this same cycle
         if (accept) begin
            for (int c = 0; c < N_CH; c++)
               snap[c] <= sample_in[c*W +: W];
            off_act  <= off_sh;
            gain_act <= gain_sh;
            byp_q    <= bypass;
            idx      <= '0;
         end

         v1 <= issue;
         if (issue) begin
            diff <= (W+1)'(snap[issue_ch]) - (W+1)'(off_act[issue_ch]);
            ch1  <= issue_ch;
            idx  <= idx + 1'b1;
         end

         if (v1)
            res[ch1] <= result_c;

         if (last) begin
            for (int c = 0; c < N_CH - 1; c++)
               sample_out[c*W +: W] <= res[c];
            sample_out[(N_CH-1)*W +: W] <= result_c;
         end
      end
   end

endmodule

// File: tb/tb_cal_sample.sv
// tb/tb_cal_sample.sv - directed vector bench for cal_sample
module tb_cal_sample;

   localparam int W  = 16;
   localparam int N  = 4;
   localparam int AW = 2;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            sample_clk = 1'b0;
   logic [N*W-1:0]  sample_in = '0;
   logic            bypass = 1'b0;
   logic            cal_we = 1'b0;
   logic            cal_sel = 1'b0;
   logic [AW-1:0]   cal_addr = '0;
   logic [W-1:0]    cal_data = '0;
   logic [N*W-1:0]  sample_out;
   logic            out_valid;
   logic            busy;
   logic [7:0]      overrun_cnt;

   cal_sample #(.W(W), .N_CH(N), .GF(14), .OFFSET_DEFAULT(3500)) dut (
      .clk(clk), .rst_n(rst_n), .sample_clk(sample_clk), .sample_in(sample_in),
      .bypass(bypass), .cal_we(cal_we), .cal_sel(cal_sel), .cal_addr(cal_addr),
      .cal_data(cal_data), .sample_out(sample_out), .out_valid(out_valid),
      .busy(busy), .overrun_cnt(overrun_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      int off0; int gain0; bit byp;
      int x0; int x1; int x2; int x3;
      int e0; int e1; int e2; int e3;
   } vec_t;

   vec_t vt [11];
   int applied = 0;
   int miscomp = 0;

   task automatic check(input string name, input int act, input int exp);
      applied++;
      if (act != exp) begin
         miscomp++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int ch_out(input int c);
      return $signed(sample_out[c*W +: W]);
   endfunction

   task automatic check_out(input string tag, input int e0, input int e1, input int e2, input int e3);
      int e [4];
      e = '{e0, e1, e2, e3};
      for (int c = 0; c < N; c++)
         check($sformatf("%s.ch%0d", tag, c), ch_out(c), e[c]);
   endtask

   task automatic write_coef(input bit sel, input int addr, input int d);
      @(negedge clk);
      cal_we = 1'b1; cal_sel = sel; cal_addr = AW'(addr); cal_data = W'(d);
      @(negedge clk);
      cal_we = 1'b0;
   endtask

   task automatic set_inputs(input int x0, input int x1, input int x2, input int x3);
      sample_in = {W'(x3), W'(x2), W'(x1), W'(x0)};
   endtask

   task automatic start_edge();
      repeat (3) @(negedge clk);
      sample_clk = 1'b1;
   endtask

   task automatic finish_frame(input string tag);
      int n, pulses, first;
      logic late_busy;
      n = 0;
      while (busy !== 1'b1 && n < 10) begin
         @(negedge clk);
         n++;
      end
      check({tag, ".busy_rise"}, int'(busy), 1);
      pulses = 0; first = -1; late_busy = 1'b1;
      for (int i = 1; i <= N + 4; i++) begin
         @(negedge clk);
         if (out_valid) begin
            pulses++;
            if (first < 0) first = i;
         end
         if (i == N + 2) late_busy = busy;
      end
      sample_clk = 1'b0;
      check({tag, ".valid_cycle"}, first, N + 1);
      check({tag, ".valid_pulses"}, pulses, 1);
      check({tag, ".busy_fall"}, int'(late_busy), 0);
   endtask

   task automatic wait_valid(input string tag);
      int n;
      n = 0;
      while (out_valid !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check({tag, ".valid_seen"}, int'(out_valid), 1);
      sample_clk = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic overrun_pair(output int pulses);
      pulses = 0;
      repeat (3) @(negedge clk);
      sample_clk = 1'b1;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         if (out_valid) pulses++;
         case (i)
            1: sample_clk = 1'b0;
            3: sample_clk = 1'b1;
            5: sample_clk = 1'b0;
            default: ;
         endcase
      end
   endtask

   initial begin
      int pulses;
      vt[0]  = '{3500, 16384, 1'b0, 10000, 3500, 0, -1, 6500, 0, -3500, -3501};
      vt[1]  = '{0, 32767, 1'b0, 20000, 32767, -32768, 100, 32767, 29267, -32768, -3400};
      vt[2]  = '{3500, 16384, 1'b0, -32768, -29268, 7, 3499, -32768, -32768, -3493, -1};
      vt[3]  = '{0, 8192, 1'b0, -1, 0, 0, 0, -1, -3500, -3500, -3500};
      vt[4]  = '{0, 8192, 1'b0, 3, 0, 0, 0, 1, -3500, -3500, -3500};
      vt[5]  = '{0, 8192, 1'b0, -3, 3500, 3501, 3499, -2, 0, 1, -1};
      vt[6]  = '{0, 8192, 1'b1, 1234, -5, 32767, -32768, 1234, -5, 32767, -32768};
      vt[7]  = '{-100, -16384, 1'b0, 100, 0, 0, 0, -200, -3500, -3500, -3500};
      vt[8]  = '{-32768, 32767, 1'b0, 32767, 0, 0, 0, 32767, -3500, -3500, -3500};
      vt[9]  = '{32767, -32768, 1'b0, -32768, 0, 0, 0, 32767, -3500, -3500, -3500};
      vt[10] = '{0, -32768, 1'b0, 20000, 0, 0, 0, -32768, -3500, -3500, -3500};

      repeat (3) @(negedge clk);
      check("reset.sample_out", int'(sample_out == '0), 1);
      check("reset.out_valid", int'(out_valid), 0);
      check("reset.busy", int'(busy), 0);
      check("reset.overrun", int'(overrun_cnt), 0);
      rst_n = 1'b1;

      for (int i = 0; i < 11; i++) begin
         string tag;
         tag = $sformatf("vec%0d", i);
         write_coef(1'b0, 0, vt[i].off0);
         write_coef(1'b1, 0, vt[i].gain0);
         bypass = vt[i].byp;
         set_inputs(vt[i].x0, vt[i].x1, vt[i].x2, vt[i].x3);
         start_edge();
         finish_frame(tag);
         check_out(tag, vt[i].e0, vt[i].e1, vt[i].e2, vt[i].e3);
         set_inputs(111, 222, 333, 444);
         repeat (3) @(negedge clk);
         check({tag, ".hold"}, ch_out(0), vt[i].e0);
      end
      bypass = 1'b0;

      // Gain write while busy lands in the shadow set only
      write_coef(1'b0, 0, 0);
      write_coef(1'b1, 0, 16384);
      set_inputs(1000, 0, 0, 0);
      start_edge();
      while (busy !== 1'b1) @(negedge clk);
      write_coef(1'b1, 0, 8192);
      wait_valid("busywr");
      check("busywr.cur", ch_out(0), 1000);
      start_edge();
      finish_frame("busywr.next");
      check("busywr.next.ch0", ch_out(0), 500);

      // Write in the snapshot cycle itself
      start_edge();
      @(negedge clk);
      @(negedge clk);
      check("snapwr.idle", int'(busy), 0);
      cal_we = 1'b1; cal_sel = 1'b1; cal_addr = '0; cal_data = W'(4096);
      @(negedge clk);
      cal_we = 1'b0;
      finish_frame("snapwr");
      check("snapwr.cur", ch_out(0), 500);
      start_edge();
      finish_frame("snapwr.next");
      check("snapwr.next.ch0", ch_out(0), 250);

      // Overruns: second edge inside a frame is dropped
      set_inputs(1000, 0, 0, 0);
      overrun_pair(pulses);
      check("ovr1.count", int'(overrun_cnt), 1);
      check("ovr1.pulses", pulses, 1);
      check_out("ovr1", 250, -3500, -3500, -3500);
      for (int i = 1; i < 300; i++) overrun_pair(pulses);
      check("ovr300.count", int'(overrun_cnt), 255);

      // Reset mid-frame at t+3
      set_inputs(10000, 3500, 0, -1);
      start_edge();
      while (busy !== 1'b1) @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      sample_clk = 1'b0;
      #1;
      check("midrst.busy", int'(busy), 0);
      check("midrst.overrun", int'(overrun_cnt), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      pulses = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (out_valid) pulses++;
      end
      check("midrst.pulses", pulses, 0);
      check("midrst.sample_out", int'(sample_out == '0), 1);
      start_edge();
      finish_frame("postrst");
      check_out("postrst", 6500, 0, -3500, -3501);

      $display("== %0d vectors applied, %0d miscompares ==", applied, miscomp);
      $finish;
   end

endmodule
